// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// function codes, FSM states and the default datapath width.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [5:0] FN_MULTU = 6'b010000;
    localparam logic [5:0] FN_MULT  = 6'b010001;
    localparam logic [5:0] FN_DIVU  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011001;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
    typedef enum logic {OP_MUL, OP_DIV} op_e;

    function automatic logic fn_valid(input logic [5:0] f);
        return (f == FN_MULTU) || (f == FN_MULT) || (f == FN_DIVU) || (f == FN_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int unsigned WIDTH = muldiv_pkg::DEF_WIDTH);

    logic             start;
    logic [5:0]       Func_in;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, Func_in, A_in, B_in, flush, hi_we, lo_we, wr_data,
        input  busy, done, dz, hi_out, lo_out
    );

    modport slave (
        input  start, Func_in, A_in, B_in, flush, hi_we, lo_we, wr_data,
        output busy, done, dz, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract
// divide on a {upper, lower} double-width accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  op_e                mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             unused_ok;

    // A successful trial leaves diff below the divisor, so diff[WIDTH] is always clear.
    assign unused_ok = diff[WIDTH];

    always_comb begin
        addend = acc[0] ? operand : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, operand};
        if (mode == OP_MUL) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning the HI/LO registers;
// operates on magnitudes and fixes signs in a final cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opnd, hi_q, lo_q;
    op_e                mode;
    logic               sign_q, sign_r, done_q, dz_q;

    logic               fn_ok, is_signed, accept, do_step, do_finish, wr_en;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        wr_en      = 1'b0;
        fn_ok      = fn_valid(bus.Func_in);
        case (state)
            IDLE: begin
                accept = bus.start && fn_ok && !bus.flush;
                wr_en  = !accept;
                if (accept) state_next = RUN;
            end
            RUN: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    do_step = 1'b1;
                    if (cnt == '0) state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
                do_finish  = !bus.flush;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_signed = bus.Func_in[0];
        mag_a     = (is_signed && bus.A_in[WIDTH-1]) ? -bus.A_in : bus.A_in;
        mag_b     = (is_signed && bus.B_in[WIDTH-1]) ? -bus.B_in : bus.B_in;
        prod_fix  = sign_q ? -acc : acc;
        quo_fix   = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode   <= OP_MUL;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cnt    <= CW'(WIDTH - 1);
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opnd   <= mag_b;
                mode   <= bus.Func_in[3] ? OP_DIV : OP_MUL;
                sign_q <= is_signed & (bus.A_in[WIDTH-1] ^ bus.B_in[WIDTH-1]);
                sign_r <= is_signed & bus.A_in[WIDTH-1];
                dz_q   <= 1'b0;
            end
            if (wr_en) begin
                if (bus.hi_we) hi_q <= bus.wr_data;
                if (bus.lo_we) lo_q <= bus.wr_data;
            end
            if (do_step) begin
                acc <= acc_step;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
            if (do_finish) begin
                done_q <= 1'b1;
                if (mode == OP_MUL) begin
                    {hi_q, lo_q} <= prod_fix;
                end else begin
                    // Zero divisor: the remainder is |A| re-signed, i.e. A as issued.
                    hi_q <= rem_fix;
                    lo_q <= (opnd == '0) ? '1 : quo_fix;
                    dz_q <= (opnd == '0);
                end
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.dz     = dz_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// per-cycle compare, directed literal cases and randomized traffic.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic void golden(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        if (f == FN_MULTU) begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (f == FN_MULT) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = '1;
        end else if (f == FN_DIVU) begin
            hi = a % b;
            lo = a / b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Model: remaining busy cycles, pending result, architectural HI/LO/dz.
    int          m_rem  = 0;
    logic [31:0] m_hi   = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz   = 1'b0, p_dz = 1'b0, m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] gh, gl;
        if (!rst_n) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dz   <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                if (bus.flush) begin
                    m_rem <= 0;
                end else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_hi   <= p_hi;
                        m_lo   <= p_lo;
                        m_dz   <= p_dz;
                        m_done <= 1'b1;
                    end
                end
            end else if (bus.start && fn_valid(bus.Func_in) && !bus.flush) begin
                golden(bus.Func_in, bus.A_in, bus.B_in, gh, gl);
                p_hi  <= gh;
                p_lo  <= gl;
                p_dz  <= bus.Func_in[3] && (bus.B_in == 32'd0);
                m_dz  <= 1'b0;
                m_rem <= W + 1;
            end else begin
                if (bus.hi_we) m_hi <= bus.wr_data;
                if (bus.lo_we) m_lo <= bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(bus.busy), 64'(m_rem > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("dz",   64'(bus.dz),   64'(m_dz));
            chk("hi",   64'(bus.hi_out), 64'(m_hi));
            chk("lo",   64'(bus.lo_out), 64'(m_lo));
        end
    end

    task automatic drive(input logic s, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic hw, input logic lw, input logic [31:0] wd);
        @(negedge clk);
        bus.start   = s;
        bus.Func_in = f;
        bus.A_in    = a;
        bus.B_in    = b;
        bus.flush   = fl;
        bus.hi_we   = hw;
        bus.lo_we   = lw;
        bus.wr_data = wd;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Issues one op and measures busy/done around it within a bounded window.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int bc, output int dc);
        drive(1'b1, f, a, b, 1'b0, 1'b0, 1'b0, 32'd0);
        idle();
        bc = 0;
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.busy) bc++;
            if (bus.done) begin
                dc++;
                break;
            end
            idle();
        end
        idle();
        if (bus.done) dc++;
    endtask

    initial begin
        int          bc, dc;
        logic [5:0]  fsel [5];
        logic [31:0] spec [5];
        logic [31:0] a, b;

        bus.start = 1'b0; bus.Func_in = '0; bus.A_in = '0; bus.B_in = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz",   64'(bus.dz),   64'd0);
        chk("rst_hi",   64'(bus.hi_out), 64'd0);
        chk("rst_lo",   64'(bus.lo_out), 64'd0);
        rst_n = 1'b1;
        idle();

        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_done_count",  64'(dc), 64'd1);
        chk("multu_hi", 64'(bus.hi_out), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(bus.lo_out), 64'h0000_0001);

        run_op(FN_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
        chk("mult_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);

        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
        chk("div_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
        chk("div_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);

        run_op(FN_DIVU, 32'd100, 32'd7, bc, dc);
        chk("divu_hi", 64'(bus.hi_out), 64'd2);
        chk("divu_lo", 64'(bus.lo_out), 64'd14);

        run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        chk("ovf_hi", 64'(bus.hi_out), 64'd0);
        chk("ovf_lo", 64'(bus.lo_out), 64'h8000_0000);

        run_op(FN_DIVU, 32'h1234, 32'd0, bc, dc);
        chk("dz_busy_cycles", 64'(bc), 64'd33);
        chk("dz_hi",   64'(bus.hi_out), 64'h1234);
        chk("dz_lo",   64'(bus.lo_out), 64'hFFFF_FFFF);
        chk("dz_flag", 64'(bus.dz), 64'd1);

        drive(1'b1, FN_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        idle();
        chk("dz_cleared", 64'(bus.dz), 64'd0);
        for (int n = 0; n < 40 && !bus.done; n++) idle();
        chk("mul6_lo", 64'(bus.lo_out), 64'd6);

        // Start at edge 0, ignored restart at edge 5, flush at edge 10.
        drive(1'b1, FN_MULTU, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (4) idle();
        drive(1'b1, FN_DIVU, 32'd77, 32'd3, 1'b0, 1'b1, 1'b1, 32'h5555);
        repeat (4) idle();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle();
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_hi", 64'(bus.hi_out), 64'd0);
        chk("flush_lo", 64'(bus.lo_out), 64'd6);
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            idle();
            if (bus.done) dc++;
        end
        chk("flush_no_done", 64'(dc), 64'd0);

        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hABCD);
        idle();
        chk("mtlo_lo", 64'(bus.lo_out), 64'hABCD);
        chk("mtlo_hi", 64'(bus.hi_out), 64'd0);

        drive(1'b1, FN_DIVU, 32'd1000, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (10) idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_hi",   64'(bus.hi_out), 64'd0);
        chk("arst_lo",   64'(bus.lo_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            idle();
            if (bus.done || bus.busy) dc++;
        end
        chk("arst_discarded", 64'(dc), 64'd0);

        fsel[0] = FN_MULTU; fsel[1] = FN_MULT; fsel[2] = FN_DIVU; fsel[3] = FN_DIV; fsel[4] = 6'd0;
        spec[0] = 32'd0; spec[1] = 32'd1; spec[2] = 32'h8000_0000; spec[3] = 32'hFFFF_FFFF; spec[4] = 32'd7;
        for (int n = 0; n < 2500; n++) begin
            logic [5:0] f;
            int unsigned k;
            k = $urandom_range(0, 4);
            f = (k == 4) ? 6'($urandom) : fsel[k];
            a = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            drive($urandom_range(0, 99) < 30, f, a, b,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom);
        end
        repeat (40) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU. It executes the ALU's reserved multiply/divide function codes, which the ALU itself does not compute.
- Owns the architectural HI/LO registers. Results feed MFHI/MFLO forwarding into the writeback mux.
- Drives a busy signal used by the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and HI/LO width; the counter is sized $clog2(WIDTH).

Ports:
- clk       input   1      rising-edge clock; the only clock
- rst_n     input   1      asynchronous active-low reset
- start     input   1      issue request; qualified by a valid muldiv Func_in
- Func_in   input   6      same function-code field as the ALU
- A_in      input   WIDTH  rs operand (multiplicand / dividend)
- B_in      input   WIDTH  rt operand (multiplier / divisor)
- flush     input   1      synchronous abort of an in-flight operation
- hi_we     input   1      MTHI write strobe
- lo_we     input   1      MTLO write strobe
- wr_data   input   WIDTH  MTHI/MTLO data
- busy      output  1      operation in flight; stall dependent MF*/MT*/muldiv
- done      output  1      one-cycle pulse when HI/LO are updated by an op
- dz        output  1      sticky divide-by-zero flag, cleared by the next accepted start
- hi_out    output  WIDTH  HI register
- lo_out    output  WIDTH  LO register

Behaviour:
- Function codes:
  - 6'b010000 MULTU
  - 6'b010001 MULT (signed)
  - 6'b011000 DIVU
  - 6'b011001 DIV (signed)
  - Any other Func_in with start=1 is ignored: no state change.
- Reset (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0, dz=0, hi_out=0, lo_out=0, counter=0.
  - Reset asserted mid-operation discards the op; HI/LO go to 0.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on an edge with start and a valid code.
    - Latch the operand magnitudes: |x| for signed ops, raw value for unsigned.
    - Latch sign_q = A[31]^B[31], sign_r = A[31] (signed ops only).
    - Set counter = WIDTH-1; set busy=1.
  - RUN, one step per cycle, WIDTH cycles:
    - Multiply: shift-add into a 2*WIDTH product register.
    - Divide: restoring shift-subtract; quotient bit = 1 when the trial remainder is non-negative.
    - Leave for FINISH when counter == 0.
  - FINISH, one cycle:
    - Apply sign correction. Multiply: negate the 64-bit product if sign_q. Divide: negate the quotient if sign_q; negate the remainder if sign_r.
    - Write HI (product[63:32] or remainder) and LO (product[31:0] or quotient).
    - Pulse done=1 in the following cycle; busy=0 in the following cycle; return to IDLE.
- Latency:
  - busy is high for exactly WIDTH+1 cycles after the accepting edge.
  - HI/LO are valid and done=1 in cycle WIDTH+2, counting the accepting edge as cycle 0.
- Divide by zero (B==0, signed or unsigned):
  - The full latency is still taken.
  - Result: LO=all ones, HI=A_in as issued (unmodified, no sign fix); dz=1.
- Signed overflow case (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. Natural result of magnitude math truncated to WIDTH.
- Handshakes and conflicts:
  - start while busy: ignored, no queueing. The stall logic must not issue; the bench checks it is ignored.
  - hi_we/lo_we are honoured only in IDLE and not on an accepting start edge; otherwise dropped.
  - hi_we and lo_we together: both written with wr_data.
- flush:
  - In RUN or FINISH: next state IDLE, busy=0, no done, HI/LO unchanged, dz unchanged.
  - In IDLE: no effect. flush beats start on the same edge.
- Outputs are registered; hi_out/lo_out have no combinational path from the inputs.

Decomposition:
- muldiv_pkg holds:
  - function-code localparams FN_MULTU, FN_MULT, FN_DIVU, FN_DIV;
  - state enum IDLE/RUN/FINISH;
  - WIDTH default.
- One sub-module, muldiv_step: a combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Output: next accumulator/quotient.
  - muldiv_unit instantiates it once and holds all registers.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after WIDTH+2 cycles HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly once; busy high 33 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234, dz=1; the next valid start clears dz.
- Conflicts: start a MULTU, pulse start with new operands at cycle 5 (ignored), flush at cycle 10 -> busy drops next cycle, no done, HI/LO keep prior values. Then MTLO 0xABCD in IDLE -> lo_out=0xABCD next cycle.
- Assert rst_n=0 asynchronously mid-RUN -> busy, done, HI, LO all 0 immediately without a clock edge; operation discarded after reset release.
